gray_conv_arbiter: RTL and testbench
====================================

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, code word width in bits; SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 offers a binary word.
REQ-005 req0_data  input  WIDTH  requester 0 binary word.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle when high with req0_valid.
REQ-007 req1_valid  input  1  requester 1 offers a binary word.
REQ-008 req1_data  input  WIDTH  requester 1 binary word.
REQ-009 req1_ready  output  1  requester 1 word accepted this cycle when high with req1_valid.
REQ-010 out_valid  output  1  result register holds a valid Gray word.
REQ-011 out_gray  output  WIDTH  Gray-coded result.
REQ-012 out_id  output  1  requester index that produced out_gray.
REQ-013 out_ready  input  1  consumer takes the result when high with out_valid.

Function
REQ-014 Block SHALL share one binary-to-Gray converter between two requesters; gray[WIDTH-1] = bin[WIDTH-1], gray[i] = bin[i+1] XOR bin[i] for i < WIDTH-1.
REQ-015 Result register state machine SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 can_accept SHALL be high when state is EMPTY, or state is FULL and out_ready=1 (same-cycle drain and refill).
REQ-017 Arbitration SHALL be round-robin on a 1-bit last_grant register: only one valid -> that requester; both valid -> requester != last_grant.
REQ-018 reqN_ready SHALL be high only when can_accept=1 and requester N is the granted requester; at most one ready SHALL be high per cycle.
REQ-019 reqN_ready MAY depend combinationally on reqN_valid and out_ready; no other combinational input-to-output path SHALL exist.
REQ-020 On acceptance the converted word SHALL load into out_gray, N into out_id, last_grant <= N, state <= FULL; latency exactly 1 cycle.
REQ-021 FULL with out_ready=1 and no acceptance SHALL go to EMPTY; FULL with out_ready=0 SHALL hold out_gray and out_id stable.
REQ-022 last_grant SHALL change only on an acceptance.
REQ-023 Sustained throughput SHALL be one word per cycle when out_ready is held high.
REQ-024 A requester SHALL hold valid and data until accepted; the block SHALL not drop or duplicate words.

Reset
REQ-025 rst=1 at a clock edge SHALL force state EMPTY, out_valid=0, out_gray=0, out_id=0, last_grant=1 (requester 0 wins the first contention).
REQ-026 rst SHALL override any acceptance or drain in the same cycle; a word in the result register is discarded.
REQ-027 While rst=1, req0_ready and req1_ready SHALL be 0.

Verification
REQ-028 After reset, req0 valid with data 4'b0110, out_ready=1 -> req0_ready=1; next cycle out_valid=1, out_gray=4'b0101, out_id=0.
REQ-029 Both valid for 4 cycles (req0=4'b1111, req1=4'b1000), out_ready=1 -> grants 0,1,0,1; outputs 1000/id0, 1100/id1, 1000/id0, 1100/id1.
REQ-030 Result FULL, out_ready=0 for 3 cycles, req1 valid -> both readys 0; out_gray and out_id unchanged; out_ready=1 -> req1 accepted in the same cycle.
REQ-031 Exhaustive sweep of bin 0..15 via req1 -> out_gray matches bin XOR (bin>>1) for every value, e.g. 4'b1011 -> 4'b1110.
REQ-032 rst asserted while FULL with both requesters valid -> next cycle out_valid=0, readys 0; after release with both valid, req0 is granted first.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gray_conv_arbiter
// Brief    : Two-requester round-robin front end sharing one binary-to-Gray
//            converter, feeding a single registered result slot.
// Revision : 1.0  initial release
// ============================================================================
module gray_conv_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_id,
    input  logic             out_ready
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_gray;
    logic             r_id;

    logic             w_can_accept;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_gray;

    // The slot can take a new word while it is being drained in the same cycle.
    assign w_can_accept = (r_state == c_EMPTY) || out_ready;

    // On contention the requester that did not win last time is granted.
    assign w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = !rst && w_can_accept && w_gnt0;
    assign req1_ready = !rst && w_can_accept && w_gnt1;
    assign w_accept   = req0_ready || req1_ready;

    assign w_bin  = w_gnt1 ? req1_data : req0_data;
    assign w_gray = w_bin ^ (w_bin >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_EMPTY;
            r_gray       <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_state      <= c_FULL;
            r_gray       <= w_gray;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
        end else if ((r_state == c_FULL) && out_ready) begin
            r_state      <= c_EMPTY;
        end
    end

    assign out_valid = (r_state == c_FULL);
    assign out_gray  = r_gray;
    assign out_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_conv_arbiter
// Brief    : Directed self-checking bench for gray_conv_arbiter (WIDTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_gray_conv_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [3:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_data;
    logic       req1_ready;
    logic       out_valid;
    logic [3:0] out_gray;
    logic       out_id;
    logic       out_ready;

    int n_cmp;
    int n_err;

    logic [3:0] c_GRAY_TBL [16];

    gray_conv_arbiter #(.WIDTH(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_gray   (out_gray),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs may then be changed safely.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        c_GRAY_TBL = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                       4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        n_cmp = 0;
        n_err = 0;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 4'h5;
        req1_valid = 1'b1;
        req1_data  = 4'hA;
        out_ready  = 1'b1;

        // Reset state, with readys forced low despite valid requesters
        tick();
        tick();
        settle();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_gray", out_gray, 0);
        check("rst_out_id", out_id, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        rst        = 1'b0;
        req1_valid = 1'b0;

        // Single request latency
        req0_data = 4'b0110;
        settle();
        check("single_req0_ready", req0_ready, 1);
        check("single_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("single_out_valid", out_valid, 1);
        check("single_out_gray", out_gray, 4'b0101);
        check("single_out_id", out_id, 0);
        tick();
        check("drain_out_valid", out_valid, 0);

        // Round-robin under sustained contention
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 4'b1111;
        req1_valid = 1'b1;
        req1_data  = 4'b1000;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("rr_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            check("rr_out_valid", out_valid, 1);
            check("rr_out_gray", out_gray, (i % 2 == 0) ? 4'b1000 : 4'b1100);
            check("rr_out_id", out_id, (i % 2 == 0) ? 0 : 1);
        end

        // Backpressure: slot full holding 1100/id1
        req0_valid = 1'b0;
        req1_data  = 4'b0011;
        out_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_req0_ready", req0_ready, 0);
            check("bp_req1_ready", req1_ready, 0);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_gray", out_gray, 4'b1100);
            check("bp_out_id", out_id, 1);
        end
        out_ready = 1'b1;
        settle();
        check("bp_release_req1_ready", req1_ready, 1);
        tick();
        check("bp_release_out_gray", out_gray, 4'b0010);
        check("bp_release_out_id", out_id, 1);

        // Exhaustive conversion via requester 1
        for (int b = 0; b < 16; b++) begin
            req1_data = 4'(b);
            settle();
            check("sweep_req1_ready", req1_ready, 1);
            tick();
            check("sweep_out_gray", out_gray, c_GRAY_TBL[b]);
            check("sweep_out_id", out_id, 1);
        end
        req1_valid = 1'b0;

        // Full slot with out_ready low and no requesters keeps its word
        out_ready = 1'b0;
        tick();
        check("hold_idle_out_valid", out_valid, 1);
        check("hold_idle_out_gray", out_gray, 4'b1000);

        // Reset while full with both requesters valid
        req0_valid = 1'b1;
        req0_data  = 4'b0111;
        req1_valid = 1'b1;
        req1_data  = 4'b0001;
        out_ready  = 1'b1;
        rst        = 1'b1;
        settle();
        check("rstfull_req0_ready", req0_ready, 0);
        check("rstfull_req1_ready", req1_ready, 0);
        tick();
        settle();
        check("rstfull_out_valid", out_valid, 0);
        check("rstfull_req0_ready2", req0_ready, 0);
        check("rstfull_req1_ready2", req1_ready, 0);
        rst = 1'b0;
        settle();
        check("postrst_req0_ready", req0_ready, 1);
        check("postrst_req1_ready", req1_ready, 0);
        tick();
        check("postrst_out_gray", out_gray, 4'b0100);
        check("postrst_out_id", out_id, 0);
        settle();
        check("postrst_next_req1_ready", req1_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
